// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/fa.sv
// One-bit full adder cell, reused bit-serially by serial_adder.
module fa (
   input  logic ai,
   input  logic bi,
   input  logic ci,
   output logic so,
   output logic co
);

   assign so = ai ^ bi ^ ci;
   assign co = (ai & bi) | (ci & (ai ^ bi));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one fa cell, LSB first, WIDTH cycles per operation,
// valid/ready on both sides with no overlap between operations.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             fa_s;
   logic             fa_co;

   fa u_fa (
      .ai (a_sr[0]),
      .bi (b_sr[0]),
      .ci (carry),
      .so (fa_s),
      .co (fa_co)
   );

   assign in_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         sum       <= '0;
         co        <= 1'b0;
         ovf       <= 1'b0;
         cnt       <= '0;
         a_sr      <= '0;
         b_sr      <= '0;
         carry     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  // Subtract is a + ~b + ~ci, so invert B and the incoming borrow.
                  a_sr  <= a;
                  b_sr  <= b ^ {WIDTH{sub}};
                  carry <= sub ? ~ci : ci;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
               sum   <= {fa_s, sum[WIDTH-1:1]};
               carry <= fa_co;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // carry still holds the carry into the MSB on this cycle.
                  co        <= fa_co;
                  ovf       <= carry ^ fa_co;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
